control_unit_pipe: RTL

Parametrised successor to the single-cycle control decode for the MIPS datapath. It decodes `imemload` into a registered control word and carries that word down a `STAGES`-deep pipeline. Each stage has a valid bit, and the pipeline supports stall, flush and sticky halt. It sits between the instruction fetch latch and the datapath, with the execute-facing fields exposed at stage 0 and the writeback-facing fields at the last stage.

---
 rtl/control_unit_pipe_if.sv | 18 +
 rtl/control_unit_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_pipe_if.sv
// Fetch-to-control handshake: instruction word with valid/ready.
interface control_unit_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] imemload;

  modport master (
    output in_valid,
    output imemload,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  imemload,
    output in_ready
  );
endinterface

// File: rtl/control_unit_pipe.sv
// MIPS control decode carried down a STAGES-deep valid/stall/flush pipe.
// Optional load-use interlock: define CONTROL_PIPE_HAZARD_EN.
package control_unit_pipe_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef struct packed {
    aluop_t     alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       lui;
    logic       beq;
    logic       bne;
    logic       jump;
    logic       jal;
    logic       jr;
    logic       dren;
    logic       dwen;
    logic       illegal;
    logic       halt;
    logic       rf_write;
    logic       memtoreg;
    logic       reads_rt;
    logic [4:0] wsel;
    logic [4:0] rs;
    logic [4:0] rt;
  } ctrl_t;
endpackage

module control_unit_pipe
  import control_unit_pipe_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic              CLK,
  input  logic              nRST,
  control_unit_pipe_if.slave bus,
  input  logic              stall,
  input  logic              flush,
  output logic [STAGES-1:0] stage_valid,
  output aluop_t            ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic              ex_lui,
  output logic              ex_beq,
  output logic              ex_bne,
  output logic              ex_jump,
  output logic              ex_jal,
  output logic              ex_jr,
  output logic              ex_dren,
  output logic              ex_dwen,
  output logic              ex_illegal,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic              wb_rf_write,
  output logic              wb_memtoreg,
  output logic              wb_jal,
  output logic [4:0]        wb_wsel,
  output logic              halted
);

  localparam int L = STAGES - 1;

  word_t             w;
  logic [5:0]        op;
  logic [5:0]        fn;
  ctrl_t             dec;
  logic              bad;
  logic              accept;
  ctrl_t             p_q [STAGES];
  logic [STAGES-1:0] v_q;

  assign w  = bus.imemload;
  assign op = w[31:26];
  assign fn = w[5:0];

  always_comb begin
    dec          = '0;
    bad          = 1'b0;
    dec.alu_op   = ALU_ADD;
    dec.rs       = w[25:21];
    dec.rt       = w[20:16];
    dec.wsel     = w[20:16];
    unique case (1'b1)
      (op == OP_RTYPE): begin
        dec.reg_dst  = 1'b1;
        dec.rf_write = 1'b1;
        dec.reads_rt = 1'b1;
        dec.wsel     = w[15:11];
        unique case (1'b1)
          (fn == F_SLL): dec.alu_op = ALU_SLL;
          (fn == F_SRL): dec.alu_op = ALU_SRL;
          (fn == F_JR): begin
            dec.jr       = 1'b1;
            dec.rf_write = 1'b0;
            dec.reads_rt = 1'b0;
          end
          (fn == F_ADD), (fn == F_ADDU): dec.alu_op = ALU_ADD;
          (fn == F_SUB), (fn == F_SUBU): dec.alu_op = ALU_SUB;
          (fn == F_AND):  dec.alu_op = ALU_AND;
          (fn == F_OR):   dec.alu_op = ALU_OR;
          (fn == F_XOR):  dec.alu_op = ALU_XOR;
          (fn == F_NOR):  dec.alu_op = ALU_NOR;
          (fn == F_SLT):  dec.alu_op = ALU_SLT;
          (fn == F_SLTU): dec.alu_op = ALU_SLTU;
          default: bad = 1'b1;
        endcase
      end
      (op == OP_J): dec.jump = 1'b1;
      (op == OP_JAL): begin
        dec.jump     = 1'b1;
        dec.jal      = 1'b1;
        dec.wsel     = 5'd31;
        dec.rf_write = 1'b1;
      end
      (op == OP_BEQ), (op == OP_BNE): begin
        dec.beq      = (op == OP_BEQ);
        dec.bne      = (op == OP_BNE);
        dec.alu_op   = ALU_SUB;
        dec.reads_rt = 1'b1;
      end
      (op == OP_ADDI), (op == OP_ADDIU): begin
        dec.alu_src  = 1'b1;
        dec.rf_write = 1'b1;
      end
      (op == OP_SLTI), (op == OP_SLTIU): begin
        dec.alu_op   = (op == OP_SLTI) ? ALU_SLT : ALU_SLTU;
        dec.alu_src  = 1'b1;
        dec.rf_write = 1'b1;
      end
      (op == OP_ANDI), (op == OP_ORI), (op == OP_XORI): begin
        dec.alu_op   = (op == OP_ANDI) ? ALU_AND :
                       (op == OP_ORI)  ? ALU_OR  : ALU_XOR;
        dec.alu_src  = 1'b1;
        dec.rf_write = 1'b1;
      end
      (op == OP_LUI): begin
        dec.lui      = 1'b1;
        dec.alu_src  = 1'b1;
        dec.rf_write = 1'b1;
      end
      (op == OP_LW): begin
        dec.dren     = 1'b1;
        dec.memtoreg = 1'b1;
        dec.alu_src  = 1'b1;
        dec.rf_write = 1'b1;
      end
      (op == OP_SW): begin
        dec.dwen     = 1'b1;
        dec.alu_src  = 1'b1;
        dec.reads_rt = 1'b1;
      end
      (op == OP_HALT): dec.halt = 1'b1;
      default: bad = 1'b1;
    endcase
    // Unknown encodings become a tagged NOP with no destination.
    if (bad) begin
      dec         = '0;
      dec.rs      = w[25:21];
      dec.rt      = w[20:16];
      dec.illegal = 1'b1;
    end
    if (dec.wsel == 5'd0) dec.rf_write = 1'b0;
  end

`ifdef CONTROL_PIPE_HAZARD_EN
  logic hazard;
  assign hazard = v_q[0] & p_q[0].dren & (p_q[0].wsel != 5'd0)
                & ((p_q[0].wsel == dec.rs)
                | (dec.reads_rt & (p_q[0].wsel == dec.rt)));
  assign bus.in_ready = ~stall & ~flush & ~halted & ~hazard;
`else
  assign bus.in_ready = ~stall & ~flush & ~halted;
`endif

  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      v_q    <= '0;
      halted <= 1'b0;
      for (int k = 0; k < STAGES; k++) p_q[k] <= '0;
    end else begin
      if (flush) begin
        v_q[0] <= 1'b0;
        p_q[0] <= '0;
      end else if (!stall) begin
        v_q[0] <= accept;
        p_q[0] <= accept ? dec : '0;
      end
      if (!stall) begin
        for (int k = 1; k < STAGES; k++) begin
          v_q[k] <= v_q[k-1];
          p_q[k] <= p_q[k-1];
        end
        if (v_q[L] && p_q[L].halt) halted <= 1'b1;
      end
    end
  end

  assign stage_valid = v_q;
  assign ex_alu_op   = p_q[0].alu_op;
  assign ex_alu_src  = p_q[0].alu_src & v_q[0];
  assign ex_reg_dst  = p_q[0].reg_dst & v_q[0];
  assign ex_lui      = p_q[0].lui & v_q[0];
  assign ex_beq      = p_q[0].beq & v_q[0];
  assign ex_bne      = p_q[0].bne & v_q[0];
  assign ex_jump     = p_q[0].jump & v_q[0];
  assign ex_jal      = p_q[0].jal & v_q[0];
  assign ex_jr       = p_q[0].jr & v_q[0];
  assign ex_dren     = p_q[0].dren & v_q[0];
  assign ex_dwen     = p_q[0].dwen & v_q[0];
  assign ex_illegal  = p_q[0].illegal & v_q[0];
  assign ex_rs       = p_q[0].rs;
  assign ex_rt       = p_q[0].rt;
  assign wb_rf_write = p_q[L].rf_write & v_q[L];
  assign wb_memtoreg = p_q[L].memtoreg & v_q[L];
  assign wb_jal      = p_q[L].jal & v_q[L];
  assign wb_wsel     = p_q[L].wsel;

endmodule
